ack_arbiter: RTL and testbench
==============================

// Module: ack_arbiter
// PURPOSE
//  Shares one wait-state peripheral slot between NREQ bus masters. Arbitrates round-robin,
//  grants one master, counts read/write wait states, then returns a one-cycle ack tagged with
//  the master's transaction id. Sits between the master muxes and a slow peripheral
//  (VIA, PSG, ...) that has no ready/ack output of its own.
// PARAMETERS
//  NREQ          4   number of requesting masters (2..8)
//  READ_STAGES   3   wait cycles inserted before a read ack (0..15)
//  WRITE_STAGES  1   wait cycles inserted before a write ack (0..15)
// PORTS
//  rst_i   in   1        synchronous reset, active high
//  clk_i   in   1        single clock; all logic on posedge clk_i
//  ce_i    in   1        clock enable; when low all state, counters and outputs hold
//  req_i   in   NREQ     per-master request (cyc&stb), held until acked
//  we_i    in   NREQ     per-master write strobe, valid while req_i high
//  id_i    in   4*NREQ   per-master transaction id, [4k+3:4k] for master k
//  lock_i  in   NREQ     per-master bus lock (used only with ACK_ARB_LOCK_EN)
//  gnt_o   out  NREQ     one-hot grant; selects the master's address/data onto the slot
//  cs_o    out  1        peripheral select, high while any grant is active (WAIT/ACK)
//  we_o    out  1        write select to the peripheral, captured at grant
//  ack_o   out  NREQ     one-hot, one-cycle acknowledge to the granted master
//  rid_o   out  4        id of the completed read, valid with ack_o
//  wid_o   out  4        id of the completed write, valid with ack_o
//  busy_o  out  1        state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, gnt_o=0, cs_o=0, we_o=0, ack_o=0, rid_o=0, wid_o=0, busy_o=0, cnt=0,
//    last=NREQ-1 (so master 0 has first priority). Reset mid-transaction aborts it with no ack.
//  - States: IDLE, WAIT, ACK, LOCKED (LOCKED is reachable only with the macro).
//  - IDLE: if any req_i is high, pick the first requester scanning last+1 .. last+NREQ (mod NREQ).
//    On that edge: gnt_o=onehot(g), cs_o=1, we_o=we_i[g], captured id=id_i[g],
//    cnt=we_i[g]?WRITE_STAGES:READ_STAGES, and go to WAIT. No request means stay in IDLE.
//  - WAIT: if req_i[g] drops, abort: go to IDLE, clear gnt_o/cs_o, no ack, last=g.
//    Else if cnt==0, go to ACK. Else cnt-=1.
//  - ACK (one cycle): ack_o[g]=1. If we_o, wid_o=captured id; else rid_o=captured id (the other
//    id output holds). Next: IDLE with last=g and gnt_o/cs_o cleared, or LOCKED (see macro).
//  - Latency: grant on edge t makes ack_o high in cycle t+1+STAGES, so with 0 stages the ack
//    lands the cycle after grant. One IDLE turnaround cycle between unlocked transactions.
//  - Master must deassert req_i the cycle after its ack. A still-high req is a new request and
//    competes at lowest priority.
//  - Simultaneous requests: exactly one grant, round-robin, so no master starves.
//    we_i/id_i changes after grant are ignored.
//  - ce_i low stretches every state. An ack that would land in a ce_i-low cycle is delayed,
//    never dropped or duplicated.
//  - gnt_o, ack_o: at most one bit set. ack_o is never set outside ACK.
// CONFIGURATION
//  ACK_ARB_LOCK_EN defined: in ACK, if lock_i[g]=1 go to LOCKED with gnt_o/cs_o kept and last
//    unchanged. LOCKED with req_i[g]=1: reload cnt from we_i[g], recapture id and we_o, go to
//    WAIT (back-to-back with no turnaround). LOCKED with lock_i[g]=0 and req_i[g]=0: go to
//    IDLE, last=g. Other masters wait while locked.
//  ACK_ARB_LOCK_EN undefined: lock_i ignored, LOCKED unreachable, always ACK->IDLE.
// TESTING
//  1 reset, req_i[2]=1, we=0, id=5, READ_STAGES=3 -> gnt_o=0100 next edge; ack_o=0100 4 cycles
//    later, one cycle wide; rid_o=5, wid_o=0.
//  2 req_i=1111 held continuously -> grant order 0,1,2,3,0; each ack matches its master's id.
//  3 write from master 1, WRITE_STAGES=1, ce_i low 2 cycles inside WAIT -> ack_o 2 cycles late,
//    wid_o=id, single pulse.
//  4 req_i[3] dropped during WAIT -> no ack_o, IDLE next cycle; pending req_i[0] granted after.
//  5 rst_i pulsed one cycle in WAIT -> all outputs 0 next cycle; master 0 wins next arbitration.
//  6 ACK_ARB_LOCK_EN, master 2 lock_i=1, two reads, req_i[0]=1 throughout -> both acks to
//    master 2 with no IDLE gap; master 0 granted only after lock_i[2]=0 and req_i[2]=0.

Source files
------------

// File: rtl/ack_arbiter.sv
// Round-robin arbiter that grants one master access to a wait-state peripheral slot and returns a tagged one-cycle ack.
// Define ACK_ARB_LOCK_EN to let a granted master hold the slot across back-to-back transactions via lock_i.
module ack_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned READ_STAGES  = 3,
  parameter int unsigned WRITE_STAGES = 1
) (
  input  logic              rst_i,
  input  logic              clk_i,
  input  logic              ce_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   we_i,
  input  logic [4*NREQ-1:0] id_i,
  input  logic [NREQ-1:0]   lock_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic              cs_o,
  output logic              we_o,
  output logic [NREQ-1:0]   ack_o,
  output logic [3:0]        rid_o,
  output logic [3:0]        wid_o,
  output logic              busy_o
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, LOCKED} state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] g;
  logic [3:0]    cnt;
  logic [3:0]    id_q;

  logic [IW-1:0] pick;
  logic          pick_vld;
  logic [IW-1:0] sel;
  logic          we_sel;
  logic [3:0]    id_sel;

  // First requester after the last-served master wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      if (!pick_vld && req_i[IW'((32'(last) + i) % NREQ)]) begin
        pick     = IW'((32'(last) + i) % NREQ);
        pick_vld = 1'b1;
      end
    end
  end

  // While locked, the reload comes from the owner rather than a fresh arbitration.
  always_comb begin
    sel    = (state == LOCKED) ? g : pick;
    we_sel = 1'b0;
    id_sel = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (sel == IW'(k)) begin
        we_sel = we_i[k];
        id_sel = id_i[4*k +: 4];
      end
    end
  end

  assign busy_o = (state != IDLE);

`ifndef ACK_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      gnt_o <= '0;
      cs_o  <= 1'b0;
      we_o  <= 1'b0;
      ack_o <= '0;
      rid_o <= '0;
      wid_o <= '0;
      cnt   <= '0;
      id_q  <= '0;
      g     <= '0;
      last  <= IW'(NREQ - 1);
    end else if (ce_i) begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            g     <= pick;
            gnt_o <= NREQ'(1) << pick;
            cs_o  <= 1'b1;
            we_o  <= we_sel;
            id_q  <= id_sel;
            cnt   <= we_sel ? 4'(WRITE_STAGES) : 4'(READ_STAGES);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!req_i[g]) begin
            state <= IDLE;
            gnt_o <= '0;
            cs_o  <= 1'b0;
            last  <= g;
          end else if (cnt == '0) begin
            state <= ACK;
            ack_o <= NREQ'(1) << g;
            if (we_o) wid_o <= id_q;
            else      rid_o <= id_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK: begin
          ack_o <= '0;
`ifdef ACK_ARB_LOCK_EN
          if (lock_i[g]) begin
            state <= LOCKED;
          end else begin
            state <= IDLE;
            gnt_o <= '0;
            cs_o  <= 1'b0;
            last  <= g;
          end
`else
          state <= IDLE;
          gnt_o <= '0;
          cs_o  <= 1'b0;
          last  <= g;
`endif
        end
        LOCKED: begin
`ifdef ACK_ARB_LOCK_EN
          if (req_i[g]) begin
            we_o  <= we_sel;
            id_q  <= id_sel;
            cnt   <= we_sel ? 4'(WRITE_STAGES) : 4'(READ_STAGES);
            state <= WAIT;
          end else if (!lock_i[g]) begin
            state <= IDLE;
            gnt_o <= '0;
            cs_o  <= 1'b0;
            last  <= g;
          end
`else
          state <= IDLE;
          gnt_o <= '0;
          cs_o  <= 1'b0;
          last  <= g;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ack_arbiter.sv
// Directed and randomized checks of ack_arbiter against a transaction-level round-robin model.
module tb_ack_arbiter;

  localparam int RS = 3;
  localparam int WS = 1;

  logic        clk_i;
  logic        rst_i;
  logic        ce_i;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [15:0] id;
  logic [3:0]  lock;
  logic [3:0]  gnt_o;
  logic        cs_o;
  logic        we_o;
  logic [3:0]  ack_o;
  logic [3:0]  rid_o;
  logic [3:0]  wid_o;
  logic        busy_o;

  int   vectors = 0;
  int   miscompares = 0;
  int   last_m;
  int   ce_edges;
  bit   rand_ce;
  bit   mw[4];
  logic [3:0] mid[4];
  logic [3:0] exp_rid;
  logic [3:0] exp_wid;

  ack_arbiter #(.NREQ(4), .READ_STAGES(RS), .WRITE_STAGES(WS)) dut (
    .rst_i (rst_i),
    .clk_i (clk_i),
    .ce_i  (ce_i),
    .req_i (req),
    .we_i  (we),
    .id_i  (id),
    .lock_i(lock),
    .gnt_o (gnt_o),
    .cs_o  (cs_o),
    .we_o  (we_o),
    .ack_o (ack_o),
    .rid_o (rid_o),
    .wid_o (wid_o),
    .busy_o(busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int predict(input logic [3:0] mask, input int last);
    for (int i = 1; i <= 4; i++)
      if (mask[(last + i) % 4]) return (last + i) % 4;
    return 0;
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    if (ce_i) ce_edges++;
    @(negedge clk_i);
    if (rand_ce) ce_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic set_req(input int m, input bit w, input logic [3:0] idv);
    req[m] = 1'b1;
    we[m]  = w;
    id[4*m +: 4] = idv;
    mw[m]  = w;
    mid[m] = idv;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    ce_i  = 1'b1;
    cyc();
    rst_i   = 1'b0;
    last_m  = 3;
    exp_rid = '0;
    exp_wid = '0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_gnt", gnt_o, 0);
    chk("rst_cs", cs_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_ack", ack_o, 0);
    chk("rst_rid", rid_o, 0);
    chk("rst_wid", wid_o, 0);
    chk("rst_busy", busy_o, 0);
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (gnt_o === '0 && n < 100) begin
      cyc();
      n++;
    end
  endtask

  task automatic run_txn(input int m, input bit drop, input bit scramble, input int nlow, output int gw);
    int n;
    int raw;
    int st;
    wait_grant(gw);
    chk("grant", gnt_o, 32'(1) << m);
    chk("cs", cs_o, 1);
    chk("we_o", we_o, mw[m]);
    chk("busy", busy_o, 1);
    if (scramble) begin
      we[m] = ~mw[m];
      id[4*m +: 4] = ~mid[m];
    end
    st = mw[m] ? WS : RS;
    ce_edges = 0;
    raw = 0;
    if (nlow > 0) begin
      ce_i = 1'b0;
      repeat (nlow) begin
        cyc();
        raw++;
      end
      ce_i = 1'b1;
    end
    while (ack_o === '0 && raw < 200) begin
      cyc();
      raw++;
    end
    chk("ack_edges", ce_edges, st + 1);
    if (!rand_ce) chk("ack_cycles", raw, st + 1 + nlow);
    chk("ack", ack_o, 32'(1) << m);
    chk("we_hold", we_o, mw[m]);
    if (mw[m]) exp_wid = mid[m];
    else       exp_rid = mid[m];
    chk("rid", rid_o, exp_rid);
    chk("wid", wid_o, exp_wid);
    if (drop) req[m] = 1'b0;
    last_m = m;
    ce_edges = 0;
    n = 0;
    while (ce_edges == 0 && n < 100) begin
      cyc();
      n++;
      if (ce_edges == 0) chk("ack_hold", ack_o, 32'(1) << m);
    end
    chk("ack_pulse", ack_o, 0);
    chk("turn_gnt", gnt_o, 0);
    chk("turn_busy", busy_o, 0);
  endtask

  initial begin
    int gw;
    int n;
    int m;
    rand_ce = 1'b0;
    ce_i = 1'b1;
    rst_i = 1'b1;
    req = '0;
    we = '0;
    id = '0;
    lock = '0;
    ce_edges = 0;
    for (int k = 0; k < 4; k++) begin
      mw[k]  = 1'b0;
      mid[k] = '0;
    end

    // 1: single read from master 2
    do_reset();
    chk_reset_outputs();
    set_req(2, 1'b0, 4'h5);
    run_txn(2, 1'b1, 1'b0, 0, gw);
    chk("t1_grant_wait", gw, 1);

    // 2: all masters requesting continuously
    do_reset();
    for (int k = 0; k < 4; k++) set_req(k, k[0], 4'(k + 1));
    for (int k = 0; k < 5; k++) run_txn(k % 4, 1'b0, 1'b0, 0, gw);
    req = '0;

    // 3: write stretched by two ce-low cycles
    set_req(1, 1'b1, 4'hA);
    run_txn(1, 1'b1, 1'b0, 2, gw);

    // 4: abort in WAIT
    set_req(3, 1'b0, 4'h3);
    wait_grant(gw);
    chk("t4_grant", gnt_o, 4'b1000);
    set_req(0, 1'b1, 4'hC);
    cyc();
    req[3] = 1'b0;
    cyc();
    chk("t4_gnt", gnt_o, 0);
    chk("t4_cs", cs_o, 0);
    chk("t4_ack", ack_o, 0);
    chk("t4_busy", busy_o, 0);
    last_m = 3;
    run_txn(predict(req, last_m), 1'b1, 1'b0, 0, gw);
    chk("t4_next_wait", gw, 1);

    // 5: reset in WAIT restores master-0 priority
    set_req(2, 1'b0, 4'h2);
    run_txn(2, 1'b1, 1'b0, 0, gw);
    set_req(3, 1'b1, 4'h9);
    set_req(0, 1'b0, 4'h1);
    wait_grant(gw);
    chk("t5_grant", gnt_o, 4'b1000);
    cyc();
    do_reset();
    chk_reset_outputs();
    run_txn(0, 1'b1, 1'b0, 0, gw);
    chk("t5_wait", gw, 1);
    run_txn(3, 1'b1, 1'b0, 0, gw);

    // 6: bus lock
`ifdef ACK_ARB_LOCK_EN
    lock[2] = 1'b1;
    set_req(2, 1'b0, 4'h6);
    wait_grant(gw);
    chk("t6_grant", gnt_o, 4'b0100);
    set_req(0, 1'b0, 4'hE);
    n = 0;
    while (ack_o === '0 && n < 200) begin
      cyc();
      n++;
      chk("t6_gnt_a", gnt_o, 4'b0100);
    end
    chk("t6_lat_a", n, RS + 1);
    chk("t6_ack_a", ack_o, 4'b0100);
    chk("t6_rid_a", rid_o, 4'h6);
    req[2] = 1'b0;
    cyc();
    chk("t6_locked_ack", ack_o, 0);
    chk("t6_locked_gnt", gnt_o, 4'b0100);
    chk("t6_locked_busy", busy_o, 1);
    set_req(2, 1'b0, 4'h7);
    cyc();
    n = 0;
    while (ack_o === '0 && n < 200) begin
      cyc();
      n++;
      chk("t6_gnt_b", gnt_o, 4'b0100);
    end
    chk("t6_lat_b", n, RS + 1);
    chk("t6_ack_b", ack_o, 4'b0100);
    chk("t6_rid_b", rid_o, 4'h7);
    exp_rid = 4'h7;
    req[2] = 1'b0;
    lock[2] = 1'b0;
    cyc();
    chk("t6_unlock_gnt", gnt_o, 0);
    chk("t6_unlock_busy", busy_o, 0);
    last_m = 2;
    run_txn(0, 1'b1, 1'b0, 0, gw);
`else
    lock[2] = 1'b1;
    set_req(2, 1'b0, 4'h6);
    run_txn(2, 1'b1, 1'b0, 0, gw);
    lock[2] = 1'b0;
`endif

    // randomized traffic with random clock enable and post-grant we/id churn
    rand_ce = 1'b1;
    for (int k = 0; k < 4; k++)
      if ($urandom_range(0, 1) != 0) set_req(k, 1'($urandom_range(0, 1)), 4'($urandom));
    for (int t = 0; t < 40; t++) begin
      if (req == '0) set_req(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom));
      m = predict(req, last_m);
      run_txn(m, 1'b1, 1'b1, 0, gw);
      for (int k = 0; k < 4; k++)
        if (!req[k] && $urandom_range(0, 1) != 0) set_req(k, 1'($urandom_range(0, 1)), 4'($urandom));
    end
    rand_ce = 1'b0;
    ce_i = 1'b1;
    req = '0;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
